// File: rtl/cpu64_writeback_unit.sv
// Writeback stage: round-robin ALU/LSU arbitration, load extraction, registered regfile write.
// Optional misaligned-load detection is enabled by defining CPU64_WB_MISALIGN_CHK_EN.
module cpu64_writeback_unit #(
  parameter int unsigned XLEN = 64  // load extraction is defined for 64 only
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_idx_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_idx_i,
  input  logic [63:0]     lsu_rdata_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [2:0]      lsu_addr_lo_i,
  output logic [4:0]      rd_idx_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic            wr_en_o,
  output logic            misalign_o,
  output logic [31:0]     retire_cnt_o
);

  typedef enum logic [0:0] {PrioAlu, PrioLsu} prio_e;

  prio_e            prio_q, prio_d;
  logic [4:0]       rd_idx_q, rd_idx_d;
  logic [XLEN-1:0]  wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             mis_q, mis_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             alu_fire, lsu_fire;
  logic             lsu_misalign;
  logic [63:0]      load_data;

  // Lanes below natural alignment are dropped by the slice indices, so an
  // unchecked misaligned access reads the aligned lane containing it.
  function automatic logic [63:0] load_extract(input logic [63:0] raw,
                                               input logic [2:0]  f3,
                                               input logic [2:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [63:0] res;
    b = raw[{lo, 3'b000} +: 8];
    h = raw[{lo[2:1], 4'b0000} +: 16];
    w = raw[{lo[2], 5'b00000} +: 32];
    case (f3)
      3'b000:  res = {{56{b[7]}}, b};
      3'b001:  res = {{48{h[15]}}, h};
      3'b010:  res = {{32{w[31]}}, w};
      3'b100:  res = {56'b0, b};
      3'b101:  res = {48'b0, h};
      3'b110:  res = {32'b0, w};
      default: res = raw;
    endcase
    return res;
  endfunction

  assign load_data = load_extract(lsu_rdata_i, lsu_funct3_i, lsu_addr_lo_i);

`ifdef CPU64_WB_MISALIGN_CHK_EN
  always_comb begin
    lsu_misalign = 1'b0;
    case (lsu_funct3_i[1:0])
      2'b01:   lsu_misalign = lsu_addr_lo_i[0];
      2'b10:   lsu_misalign = |lsu_addr_lo_i[1:0];
      2'b11:   lsu_misalign = |lsu_addr_lo_i;
      default: lsu_misalign = 1'b0;
    endcase
  end
`else
  assign lsu_misalign = 1'b0;
`endif

  // Ready never looks at the same source's valid, only the competitor's.
  assign alu_ready_o = !lsu_valid_i || (prio_q == PrioAlu);
  assign lsu_ready_o = !alu_valid_i || (prio_q == PrioLsu);
  assign alu_fire    = alu_valid_i && alu_ready_o;
  assign lsu_fire    = lsu_valid_i && lsu_ready_o;

  always_comb begin
    prio_d    = prio_q;
    rd_idx_d  = '0;
    wr_data_d = '0;
    wr_en_d   = 1'b0;
    mis_d     = 1'b0;
    cnt_d     = cnt_q;
    // Contention always yields a transfer, so priority alternates on each one.
    if (alu_valid_i && lsu_valid_i) begin
      prio_d = (prio_q == PrioAlu) ? PrioLsu : PrioAlu;
    end
    if (alu_fire) begin
      rd_idx_d  = alu_rd_idx_i;
      wr_data_d = alu_data_i;
      wr_en_d   = |alu_rd_idx_i;
      cnt_d     = cnt_q + 32'd1;
    end else if (lsu_fire) begin
      rd_idx_d  = lsu_rd_idx_i;
      wr_data_d = load_data;
      wr_en_d   = (|lsu_rd_idx_i) && !lsu_misalign;
      mis_d     = lsu_misalign;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q    <= PrioAlu;
      rd_idx_q  <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      mis_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      prio_q    <= prio_d;
      rd_idx_q  <= rd_idx_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      mis_q     <= mis_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_idx_o     = rd_idx_q;
  assign wr_data_o    = wr_data_q;
  assign wr_en_o      = wr_en_q;
  assign misalign_o   = mis_q;
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_cpu64_writeback_unit.sv
// Self-checking bench for cpu64_writeback_unit: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_cpu64_writeback_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, lsu_valid_i;
  logic        alu_ready_o, lsu_ready_o;
  logic [4:0]  alu_rd_idx_i, lsu_rd_idx_i;
  logic [63:0] alu_data_i, lsu_rdata_i;
  logic [2:0]  lsu_funct3_i, lsu_addr_lo_i;
  logic [4:0]  rd_idx_o;
  logic [63:0] wr_data_o;
  logic        wr_en_o, misalign_o;
  logic [31:0] retire_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  cpu64_writeback_unit #(.XLEN(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alu_valid_i  (alu_valid_i),
    .alu_ready_o  (alu_ready_o),
    .alu_rd_idx_i (alu_rd_idx_i),
    .alu_data_i   (alu_data_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rd_idx_i (lsu_rd_idx_i),
    .lsu_rdata_i  (lsu_rdata_i),
    .lsu_funct3_i (lsu_funct3_i),
    .lsu_addr_lo_i(lsu_addr_lo_i),
    .rd_idx_o     (rd_idx_o),
    .wr_data_o    (wr_data_o),
    .wr_en_o      (wr_en_o),
    .misalign_o   (misalign_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load semantics as plain arithmetic: width in bytes, aligned offset, mask, sign fill.
  function automatic void model_load(input logic [63:0] raw, input logic [2:0] f3,
                                     input logic [2:0] lo, output logic [63:0] val,
                                     output logic mis);
    int w;
    int off;
    logic [63:0] mask;
    w    = 1 << f3[1:0];
    off  = int'(lo) - (int'(lo) % w);
    mask = (w == 8) ? {64{1'b1}} : ((64'd1 << (w * 8)) - 64'd1);
    val  = (raw >> (off * 8)) & mask;
    if (!f3[2] && w < 8 && val[w*8-1]) val = val | ~mask;
`ifdef CPU64_WB_MISALIGN_CHK_EN
    mis = (int'(lo) % w) != 0;
`else
    mis = 1'b0;
`endif
  endfunction

  // Model state: whose turn it is under contention, and what the next edge must produce.
  bit          m_prio_lsu;
  logic [31:0] m_cnt;
  logic        e_wr_en, e_mis;
  logic [4:0]  e_rd;
  logic [63:0] e_data;

  always @(negedge clk_i) begin
    logic        ga, gl, lmis;
    logic [63:0] lval;
    if (rst_i) begin
      m_prio_lsu = 1'b0;
      m_cnt   = '0;
      e_wr_en = 1'b0;
      e_mis   = 1'b0;
      e_rd    = '0;
      e_data  = '0;
      chk("rst_wr_en", 64'(wr_en_o), 64'd0);
      chk("rst_rd_idx", 64'(rd_idx_o), 64'd0);
      chk("rst_wr_data", wr_data_o, 64'd0);
      chk("rst_misalign", 64'(misalign_o), 64'd0);
      chk("rst_retire_cnt", 64'(retire_cnt_o), 64'd0);
    end else begin
      chk("wr_en", 64'(wr_en_o), 64'(e_wr_en));
      chk("misalign", 64'(misalign_o), 64'(e_mis));
      chk("retire_cnt", 64'(retire_cnt_o), 64'(m_cnt));
      if (e_wr_en) begin
        chk("rd_idx", 64'(rd_idx_o), 64'(e_rd));
        chk("wr_data", wr_data_o, e_data);
      end
      chk("alu_ready", 64'(alu_ready_o), 64'(!lsu_valid_i || !m_prio_lsu));
      chk("lsu_ready", 64'(lsu_ready_o), 64'(!alu_valid_i || m_prio_lsu));
      // Grant for the coming edge.
      if (alu_valid_i && lsu_valid_i) begin
        ga = !m_prio_lsu;
        gl = m_prio_lsu;
        m_prio_lsu = !m_prio_lsu;
      end else begin
        ga = alu_valid_i;
        gl = lsu_valid_i;
      end
      e_wr_en = 1'b0;
      e_mis   = 1'b0;
      if (ga) begin
        e_rd    = alu_rd_idx_i;
        e_data  = alu_data_i;
        e_wr_en = alu_rd_idx_i != 0;
        m_cnt   = m_cnt + 1;
      end else if (gl) begin
        model_load(lsu_rdata_i, lsu_funct3_i, lsu_addr_lo_i, lval, lmis);
        e_rd    = lsu_rd_idx_i;
        e_data  = lval;
        e_mis   = lmis;
        e_wr_en = (lsu_rd_idx_i != 0) && !lmis;
        m_cnt   = m_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic lsu_one(input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] raw,
                         input logic [4:0] rd);
    lsu_valid_i = 1'b1;
    lsu_funct3_i = f3;
    lsu_addr_lo_i = lo;
    lsu_rdata_i = raw;
    lsu_rd_idx_i = rd;
    step();
    lsu_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    alu_rd_idx_i = '0;
    alu_data_i = '0;
    lsu_rd_idx_i = '0;
    lsu_rdata_i = '0;
    lsu_funct3_i = '0;
    lsu_addr_lo_i = '0;
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_cnt", 64'(retire_cnt_o), 64'd0);
    chk("reset_wr_en", 64'(wr_en_o), 64'd0);

    // Single ALU result.
    step();
    alu_valid_i = 1'b1;
    alu_rd_idx_i = 5'd5;
    alu_data_i = 64'h1234;
    step();
    alu_valid_i = 1'b0;
    @(negedge clk_i);
    chk("alu_wr_en", 64'(wr_en_o), 64'd1);
    chk("alu_rd", 64'(rd_idx_o), 64'd5);
    chk("alu_data", wr_data_o, 64'h1234);
    chk("alu_cnt", 64'(retire_cnt_o), 64'd1);
    @(negedge clk_i);
    chk("alu_one_cycle", 64'(wr_en_o), 64'd0);

    // Contention from reset: ALU, LSU, ALU, LSU.
    pulse_reset();
    alu_valid_i = 1'b1;
    alu_rd_idx_i = 5'd1;
    alu_data_i = 64'hAAAA;
    lsu_valid_i = 1'b1;
    lsu_rd_idx_i = 5'd2;
    lsu_funct3_i = 3'b011;
    lsu_addr_lo_i = 3'd0;
    lsu_rdata_i = 64'hBBBB;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
      end
      @(negedge clk_i);
      chk("rr_wr_en", 64'(wr_en_o), 64'd1);
      chk("rr_rd", 64'(rd_idx_o), (k % 2 == 0) ? 64'd1 : 64'd2);
    end
    chk("rr_cnt", 64'(retire_cnt_o), 64'd4);

    // Load extraction.
    step();
    lsu_one(3'b000, 3'd7, 64'h80FF_0000_0000_0000, 5'd3);
    chk("lb", wr_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    lsu_one(3'b100, 3'd7, 64'h80FF_0000_0000_0000, 5'd3);
    chk("lbu", wr_data_o, 64'h80);
    step();
    lsu_one(3'b110, 3'd4, 64'h80FF_0000_0000_0000, 5'd3);
    chk("lwu", wr_data_o, 64'h80FF_0000);

    // ALU write to x0: accepted and counted, no write strobe.
    step();
    alu_valid_i = 1'b1;
    alu_rd_idx_i = 5'd0;
    alu_data_i = 64'hDEAD;
    @(negedge clk_i);
    chk("x0_ready", 64'(alu_ready_o), 64'd1);
    step();
    alu_valid_i = 1'b0;
    @(negedge clk_i);
    chk("x0_wr_en", 64'(wr_en_o), 64'd0);
    chk("x0_cnt", 64'(retire_cnt_o), 64'd8);

    // Misaligned LW.
    step();
    lsu_one(3'b010, 3'd2, 64'h1122_3344_8765_4321, 5'd4);
`ifdef CPU64_WB_MISALIGN_CHK_EN
    chk("lw_mis_wr_en", 64'(wr_en_o), 64'd0);
    chk("lw_mis_pulse", 64'(misalign_o), 64'd1);
    @(negedge clk_i);
    chk("lw_mis_one_cycle", 64'(misalign_o), 64'd0);
`else
    chk("lw_mis_wr_en", 64'(wr_en_o), 64'd1);
    chk("lw_mis_data", wr_data_o, 64'hFFFF_FFFF_8765_4321);
`endif
    chk("lw_cnt", 64'(retire_cnt_o), 64'd9);

    // Reset asserted while a write is on the outputs.
    step();
    alu_valid_i = 1'b1;
    alu_rd_idx_i = 5'd3;
    alu_data_i = 64'h77;
    step();
    alu_valid_i = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    chk("arst_wr_en", 64'(wr_en_o), 64'd0);
    chk("arst_rd", 64'(rd_idx_o), 64'd0);
    chk("arst_data", wr_data_o, 64'd0);
    chk("arst_cnt", 64'(retire_cnt_o), 64'd0);
    step();
    rst_i = 1'b0;
    alu_valid_i = 1'b1;
    alu_rd_idx_i = 5'd9;
    lsu_valid_i = 1'b1;
    lsu_rd_idx_i = 5'd10;
    lsu_funct3_i = 3'b011;
    lsu_addr_lo_i = 3'd0;
    step();
    alu_valid_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_grant", 64'(rd_idx_o), 64'd9);
    step();
    lsu_valid_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_lsu", 64'(rd_idx_o), 64'd10);

    // Randomized traffic; payloads held until their transfer.
    for (int i = 0; i < 3000; i++) begin
      logic af, lf;
      @(negedge clk_i);
      af = alu_valid_i && alu_ready_o && !rst_i;
      lf = lsu_valid_i && lsu_ready_o && !rst_i;
      step();
      if (!alu_valid_i || af) begin
        alu_valid_i = ($urandom_range(3) != 0);
        alu_rd_idx_i = 5'($urandom_range(31));
        alu_data_i = {$urandom, $urandom};
      end
      if (!lsu_valid_i || lf) begin
        lsu_valid_i = ($urandom_range(3) != 0);
        lsu_rd_idx_i = 5'($urandom_range(31));
        lsu_rdata_i = {$urandom, $urandom};
        lsu_funct3_i = 3'($urandom_range(7));
        lsu_addr_lo_i = 3'($urandom_range(7));
      end
    end
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
